uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer directly downstream of the UART receiver. It captures each completed byte on the rising edge of the receiver's `done` and stores it in a first-word-fall-through FIFO. It presents the bytes to the host with a pop handshake and raises level, overflow and idle-timeout indications for interrupt logic.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `THRESHOLD`, 8: `thresh_irq` asserts when `level` ≥ `THRESHOLD`; range 1..DEPTH.
- `TIMEOUT_CHARS`, 4: idle character times before timeout.

Ports:
- `clk` in 1: clock.
- `rstN` in 1: reset, asynchronous, active-low.
- `rx_done` in 1: receiver done; a level signal, held high until the next frame starts.
- `rx_busy` in 1: receiver frame in progress.
- `rx_data` in 8: receiver parallel byte; valid while `rx_done` is high.
- `s_tick` in 1: oversample tick, the same one that feeds the receiver.
- `rd_en` in 1: pop request.
- `flush` in 1: synchronous clear of the FIFO contents.
- `clr_overflow` in 1: clears the sticky overflow flag.
- `rd_data` out 8: head byte; 8'h00 when empty.
- `empty` out 1, `full` out 1.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; a byte was dropped.
- `thresh_irq` out 1.
- `timeout_irq` out 1.

## Operation
- Push detect: register `rx_done` into `done_d`. `push = rx_done & ~done_d`, exactly one push per frame. `rx_data` is sampled in the same cycle as the push.
- Pointers: `wr_ptr` and `rd_ptr` are AW+1 bits wide, with AW = $clog2(DEPTH). The MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - `level = wr_ptr - rd_ptr`, computed modulo 2^(AW+1).
- Pop: `pop = rd_en & ~empty`. `rd_en` while empty is ignored; no pointer change and no error.
- Push while not full writes `mem[wr_ptr[AW-1:0]]` and increments `wr_ptr`.
- Push while full with no pop: the byte is dropped and `overflow` is set.
- Push and pop in the same cycle while full: both occur, the level is unchanged, no overflow.
- Push and pop in the same cycle while empty: the push occurs and the pop is ignored.
- `overflow` is sticky. `clr_overflow` clears it. If set and clear coincide, set wins.
- `flush`:
  - Zeroes both pointers.
  - Drops a coincident push.
  - Does not affect `overflow`.
  - Clears `timeout_irq` and the timeout counter.
- `thresh_irq` = `level` ≥ `THRESHOLD`; combinational from registered pointers.
- Reset mid-frame: all state is cleared. `done_d` resets to 0, so a `rx_done` already high after reset release produces one push. This is the intended behaviour.

## Timing
- Reset values:
  - `rd_data` = 0, `empty` = 1, `full` = 0, `level` = 0.
  - `overflow` = 0, `thresh_irq` = 0, `timeout_irq` = 0.
  - Pointers, `done_d` and the timeout counter = 0.
- Push latency: `rx_done` rises in cycle N and is registered in N+1 as part of the receiver's registered output. `push` is high in cycle N. `empty` falls, and `level` and `rd_data` update, in N+1.
- Pop: `rd_data` shows the head combinationally from memory. `rd_en` high in cycle N advances `rd_data` to the next entry in N+1.
- `full`, `empty` and `level` all derive from the pointers; there is no extra pipeline stage.

## Configuration
- Macro `UART_RX_TIMEOUT_EN`.
- Defined:
  - A counter advances on `s_tick` while the FIFO is non-empty, `rx_busy` is low, and there is no push or pop that cycle.
  - Any push, pop or flush resets the counter.
  - When the counter reaches `TIMEOUT_CHARS*10*OVERSAMPLE_RATE - 1` and another tick arrives, `timeout_irq` sets.
  - `timeout_irq` stays set until the next pop, push or flush.
  - Counter width is $clog2 of the limit.
- Undefined: no counter is built and `timeout_irq` is tied to 0.

## Structure
- `definitions_pkg` additions:
  - `OVERSAMPLE_RATE`, already present.
  - `RX_FIFO_DEPTH`, `RX_FIFO_THRESHOLD`, `RX_TIMEOUT_CHARS`.
  - `FRAME_BITS = 10`.
- Parameter defaults come from these package constants.
- One sub-module, `uart_fifo_mem`: simple dual-port register array with one synchronous write port and one asynchronous read port, parameterised by DEPTH and WIDTH. No reset on the storage.

## Test plan
- Three frames 8'hA5, 8'h3C, 8'hFF, each with `rx_done` held high 40 cycles → `level` = 3 (no duplicate pushes). Popping gives A5, 3C, FF, then `empty` = 1 and `rd_data` = 0.
- Push 17 bytes (0x00..0x10) with DEPTH=16 → `full` = 1 after the 16th and `overflow` = 1 after the 17th. Pops return 0x00..0x0F. `clr_overflow` then clears `overflow`.
- Full FIFO, push and pop in the same cycle → `level` stays 16, `overflow` stays 0, and the new byte is read last.
- Fill to 8 → `thresh_irq` rises on the 8th push and falls after one pop.
- `flush` coinciding with a push at level 5 → `level` = 0, `empty` = 1, `overflow` unchanged.
- With `UART_RX_TIMEOUT_EN`, OVERSAMPLE_RATE=16, 1 byte stored and the receiver idle → `timeout_irq` sets after 640 `s_tick`s and clears on pop. Without the macro, `timeout_irq` stays 0.

Source files
------------

// File: rtl/definitions_pkg.sv
// Shared constants for the UART receive path.
// Frame timing and receive-FIFO defaults live here.
package definitions_pkg;

  localparam int OVERSAMPLE_RATE   = 16;
  localparam int FRAME_BITS        = 10;
  localparam int RX_FIFO_DEPTH     = 16;
  localparam int RX_FIFO_THRESHOLD = 8;
  localparam int RX_TIMEOUT_CHARS  = 4;

  function automatic int rx_timeout_limit(input int chars);
    return chars * FRAME_BITS * OVERSAMPLE_RATE;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: sync write, async read.
// Storage carries no reset; validity is tracked by the pointers.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver, FWFT with level/overflow irqs.
// Define UART_RX_TIMEOUT_EN to build the idle-timeout counter.
import definitions_pkg::*;

module uart_rx_fifo #(
  parameter int DEPTH         = RX_FIFO_DEPTH,
  parameter int THRESHOLD     = RX_FIFO_THRESHOLD,
  parameter int TIMEOUT_CHARS = RX_TIMEOUT_CHARS
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     rx_done,
  input  logic                     rx_busy,
  input  logic [7:0]               rx_data,
  input  logic                     s_tick,
  input  logic                     rd_en,
  input  logic                     flush,
  input  logic                     clr_overflow,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     thresh_irq,
  output logic                     timeout_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic          done_d;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          ovf_set;
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [7:0]    mem_rdata;

  assign push = rx_done & ~done_d;
  assign pop  = rd_en & ~empty & ~flush;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &
                 (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

  // A pop in the same cycle frees the slot the push lands in.
  assign wr_en   = push & ~flush & (~full | pop);
  assign ovf_set = push & ~flush & full & ~pop;

  assign thresh_irq = (level >= LW'(THRESHOLD));
  assign rd_data    = empty ? 8'h00 : mem_rdata;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      done_d <= 1'b0;
    end else begin
      done_d <= rx_done;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + LW'(1);
      if (pop)   rd_ptr <= rd_ptr + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (mem_rdata)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int LIMIT = TIMEOUT_CHARS * FRAME_BITS * OVERSAMPLE_RATE;
  localparam int CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] to_cnt;
  logic          to_irq;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      to_cnt <= '0;
      to_irq <= 1'b0;
    end else if (flush | push | pop) begin
      to_cnt <= '0;
      to_irq <= 1'b0;
    end else if (s_tick & ~empty & ~rx_busy) begin
      // Counter parks at the limit once the irq is raised.
      if (to_cnt == CW'(LIMIT - 1)) begin
        to_irq <= 1'b1;
      end else begin
        to_cnt <= to_cnt + CW'(1);
      end
    end
  end

  assign timeout_irq = to_irq;
`else
  logic unused_to;
  assign unused_to   = ^{s_tick, rx_busy, TIMEOUT_CHARS[0]};
  assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo with default parameters.
// Pops queue expected bytes; a monitor compares on every accepted pop.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rstN;
  logic       rx_done;
  logic       rx_busy;
  logic [7:0] rx_data;
  logic       s_tick;
  logic       rd_en;
  logic       flush;
  logic       clr_overflow;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       overflow;
  logic       thresh_irq;
  logic       timeout_irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo dut (
    .clk          (clk),
    .rstN         (rstN),
    .rx_done      (rx_done),
    .rx_busy      (rx_busy),
    .rx_data      (rx_data),
    .s_tick       (s_tick),
    .rd_en        (rd_en),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .level        (level),
    .overflow     (overflow),
    .thresh_irq   (thresh_irq),
    .timeout_irq  (timeout_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstN && rd_en && !empty) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL pop_data: got %0h with no byte expected", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_errors++;
          $display("FAIL pop_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_busy = 1'b0;
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) cyc();
    rx_done = 1'b0;
    rx_busy = 1'b1;
    cyc();
    rx_busy = 1'b0;
  endtask

  task automatic pop(input logic [7:0] e);
    exp_q.push_back(e);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    rx_done = 1'b0;
    rx_busy = 1'b0;
    rx_data = 8'h00;
    s_tick = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) cyc();
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_level", int'(level), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_thresh", int'(thresh_irq), 0);
    check("rst_timeout", int'(timeout_irq), 0);
    rstN = 1'b1;
    cyc();

    send_byte(8'hA5, 40);
    send_byte(8'h3C, 40);
    send_byte(8'hFF, 40);
    check("three_level", int'(level), 3);
    check("three_head", int'(rd_data), 8'hA5);
    pop(8'hA5);
    pop(8'h3C);
    pop(8'hFF);
    check("three_empty", int'(empty), 1);
    check("three_rd_zero", int'(rd_data), 0);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    check("pop_empty_level", int'(level), 0);

    for (int i = 0; i < 16; i++) send_byte(8'(i), 2);
    check("fill_full", int'(full), 1);
    check("fill_no_ovf", int'(overflow), 0);
    check("fill_level", int'(level), 16);
    send_byte(8'h10, 2);
    check("ovf_set", int'(overflow), 1);
    check("ovf_level", int'(level), 16);
    for (int i = 0; i < 16; i++) pop(8'(i));
    check("drain_empty", int'(empty), 1);

    for (int i = 0; i < 4; i++) send_byte(8'(8'h60 + i), 2);
    rx_data = 8'h64;
    rx_done = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    rx_done = 1'b0;
    cyc();
    check("flush_level", int'(level), 0);
    check("flush_empty", int'(empty), 1);
    check("flush_ovf_kept", int'(overflow), 1);
    clr_overflow = 1'b1;
    cyc();
    clr_overflow = 1'b0;
    check("ovf_cleared", int'(overflow), 0);

    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 2);
    exp_q.push_back(8'h20);
    rx_data = 8'h55;
    rx_done = 1'b1;
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    cyc();
    rx_done = 1'b0;
    cyc();
    check("pp_full_level", int'(level), 16);
    check("pp_full_ovf", int'(overflow), 0);
    for (int i = 1; i < 16; i++) pop(8'(8'h20 + i));
    pop(8'h55);
    check("pp_drained", int'(empty), 1);

    for (int i = 0; i < 7; i++) send_byte(8'(8'h40 + i), 2);
    check("th_below", int'(thresh_irq), 0);
    send_byte(8'h47, 2);
    check("th_at", int'(thresh_irq), 1);
    pop(8'h40);
    check("th_after_pop", int'(thresh_irq), 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("th_flushed", int'(empty), 1);

    send_byte(8'h99, 2);
`ifdef UART_RX_TIMEOUT_EN
    s_tick = 1'b1;
    repeat (639) cyc();
    s_tick = 1'b0;
    check("to_639", int'(timeout_irq), 0);
    s_tick = 1'b1;
    cyc();
    s_tick = 1'b0;
    check("to_640", int'(timeout_irq), 1);
    pop(8'h99);
    check("to_pop_clear", int'(timeout_irq), 0);
`else
    s_tick = 1'b1;
    repeat (700) cyc();
    s_tick = 1'b0;
    check("to_disabled", int'(timeout_irq), 0);
    pop(8'h99);
`endif

    cyc();
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
